// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the byte-serial memory access sequencer.
package mem_seq_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int BYTE_WIDTH    = 8;
  localparam int LANES         = DATA_WIDTH / BYTE_WIDTH;
  localparam int IDX_WIDTH     = $clog2(LANES);

  typedef enum logic [1:0] {
    SIZE_B    = 2'b00,
    SIZE_H    = 2'b01,
    SIZE_W    = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Index of the final byte access for a given request size.
  function automatic logic [IDX_WIDTH-1:0] last_index(input size_e size);
    case (size)
      SIZE_B:  last_index = IDX_WIDTH'(0);
      SIZE_H:  last_index = IDX_WIDTH'(1);
      default: last_index = IDX_WIDTH'(LANES - 1);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Core-side request/response channel of the memory access sequencer.
interface mem_access_sequencer_if;
  import mem_seq_pkg::*;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;

  // Core / pipeline side.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_access_sequencer_load_extend.sv
// Sign/zero extension of the assembled little-endian load buffer.
module load_extend
  import mem_seq_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] buffer,
  input  size_e                 size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] ext
);

  // Replicate the top bit of the loaded width unless zero-extension is asked for.
  always_comb begin
    ext = '0;
    case (size)
      SIZE_B: ext = {{(DATA_WIDTH-BYTE_WIDTH){~is_unsigned & buffer[BYTE_WIDTH-1]}},
                     buffer[BYTE_WIDTH-1:0]};
      SIZE_H: ext = {{(DATA_WIDTH-2*BYTE_WIDTH){~is_unsigned & buffer[2*BYTE_WIDTH-1]}},
                     buffer[2*BYTE_WIDTH-1:0]};
      SIZE_W: ext = buffer;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Splits 32-bit loads/stores into 1/2/4 little-endian byte accesses on the
// byte-wide data memory port and returns one (extended) response.
//
// state  | meaning
// IDLE   | ready for a request; memory port parked (we=0, addr=0)
// ACCESS | one byte access per cycle, index 0..N-1
// RESP   | response held until consumed
module mem_access_sequencer
  import mem_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  mem_access_sequencer_if.slave    core,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_we,
  output logic [BYTE_WIDTH-1:0]    mem_wd,
  input  logic [BYTE_WIDTH-1:0]    mem_rd
);

  state_e                   state_q;
  logic [IDX_WIDTH-1:0]     idx_q;
  logic [IDX_WIDTH-1:0]     idx_nxt;
  logic                     we_q;
  size_e                    size_q;
  logic                     uns_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    buf_q;
  logic [DATA_WIDTH-1:0]    buf_nxt;
  logic [DATA_WIDTH-1:0]    ext_data;
  size_e                    req_size_e;

  assign req_size_e = size_e'(core.req_size);
  assign idx_nxt    = idx_q + IDX_WIDTH'(1);

  // Load buffer including the byte being read this cycle, so the final
  // response can be registered on the same edge as the last access.
  always_comb begin
    buf_nxt = buf_q;
    if (!we_q) begin
      buf_nxt[BYTE_WIDTH*idx_q +: BYTE_WIDTH] = mem_rd;
    end
  end

  load_extend u_load_extend (
    .buffer      (buf_nxt),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext         (ext_data)
  );

  // Sequencer FSM with registered memory-port and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      we_q           <= 1'b0;
      size_q         <= SIZE_B;
      uns_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      buf_q          <= '0;
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_wd         <= '0;
      core.req_ready <= 1'b1;
      core.rsp_valid <= 1'b0;
      core.rsp_err   <= 1'b0;
      core.rsp_rdata <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (core.req_valid) begin
            we_q           <= core.req_we;
            size_q         <= req_size_e;
            uns_q          <= core.req_unsigned;
            addr_q         <= core.req_addr;
            wdata_q        <= core.req_wdata;
            idx_q          <= '0;
            buf_q          <= '0;
            core.req_ready <= 1'b0;
            if (req_size_e == SIZE_RSVD) begin
              state_q        <= RESP;
              core.rsp_valid <= 1'b1;
              core.rsp_err   <= 1'b1;
              core.rsp_rdata <= '0;
            end else begin
              state_q  <= ACCESS;
              mem_addr <= core.req_addr;
              mem_we   <= core.req_we;
              mem_wd   <= core.req_wdata[BYTE_WIDTH-1:0];
            end
          end
        end
        ACCESS: begin
          buf_q <= buf_nxt;
          if (idx_q == last_index(size_q)) begin
            state_q        <= RESP;
            mem_addr       <= '0;
            mem_we         <= 1'b0;
            mem_wd         <= '0;
            core.rsp_valid <= 1'b1;
            core.rsp_err   <= 1'b0;
            core.rsp_rdata <= we_q ? '0 : ext_data;
          end else begin
            idx_q    <= idx_nxt;
            // Address arithmetic wraps naturally at the top of the space.
            mem_addr <= addr_q + ADDRESS_WIDTH'(idx_nxt);
            mem_wd   <= wdata_q[BYTE_WIDTH*idx_nxt +: BYTE_WIDTH];
          end
        end
        RESP: begin
          if (core.rsp_ready) begin
            state_q        <= IDLE;
            core.rsp_valid <= 1'b0;
            core.rsp_err   <= 1'b0;
            core.rsp_rdata <= '0;
            core.req_ready <= 1'b1;
          end
        end
        default: begin
          state_q        <= IDLE;
          core.req_ready <= 1'b1;
          mem_we         <= 1'b0;
          mem_addr       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench: stimulus pushes expected responses, a monitor pops them.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wd;
  logic [7:0]  mem_rd;
  logic [7:0]  tb_mem [0:1023];

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_access_sequencer_if bus();

  mem_access_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .core     (bus.slave),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  // Byte memory model: combinational read, write at the rising edge.
  assign mem_rd = tb_mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr[9:0]] <= mem_wd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with nothing expected",
                 bus.rsp_rdata, bus.rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
      end
    end
  end

  // Issue one request starting just after a rising edge; checks per-cycle
  // memory traffic and response timing. hold > 0 stalls rsp_ready and tries
  // to slip in a stray store while the response is pending.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int hold);
    int   n;
    rsp_t e;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.rsp_ready    = (hold == 0);
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    e.rdata = exp_rdata;
    e.err   = (size == 2'b11);
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("mem_addr", mem_addr, addr + 32'(k));
      check("mem_we", 32'(mem_we), 32'(we));
      if (we) check("mem_wd", 32'(mem_wd), (wdata >> (8 * k)) & 32'hFF);
      check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      check("rsp_valid_early", 32'(bus.rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rsp_rdata", bus.rsp_rdata, exp_rdata);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_mem_we", 32'(mem_we), 32'd0);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'b00;
      bus.req_addr  = 32'h300;
      bus.req_wdata = 32'h5A;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("resp_mem_we", 32'(mem_we), 32'd0);
    check("resp_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wd", 32'(mem_wd), 32'd0);
    @(posedge clk); #1;

    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFFDEAD, 0);
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h000000DE, 0);
    do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hFFFFFFEF, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 32'h0000ADBE, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);

    // Address wrap across the top of the space.
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h44332211, 32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h44332211, 0);

    // Reserved size.
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 0);

    // Back-pressure with a stray request that must be ignored.
    do_req(1'b1, 2'b00, 1'b0, 32'h300, 32'h77, 32'h0, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    check("stray_store_ignored", 32'(tb_mem[10'h300]), 32'h77);
    do_req(1'b0, 2'b00, 1'b1, 32'h300, 32'h0, 32'h77, 0);

    // Reset during the second byte of a word store.
    do_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, 32'h0, 0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h200;
    bus.req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_addr", mem_addr, 32'h201);
    check("rst_mid_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("post_rst_mem_we", 32'(mem_we), 32'd0);
      check("post_rst_mem_addr", mem_addr, 32'd0);
      @(posedge clk); #1;
    end
    check("mem_200", 32'(tb_mem[10'h200]), 32'hDD);
    check("mem_201", 32'(tb_mem[10'h201]), 32'hCC);
    check("mem_202", 32'(tb_mem[10'h202]), 32'h22);
    check("mem_203", 32'(tb_mem[10'h203]), 32'h11);
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h1122CCDD, 0);

    repeat (2) @(posedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
